// File: rtl/alien_row_sched.sv
// Shares one Alien2 sprite ROM across a row of aliens: decodes which alien covers the
// current pixel, generates the ROM address and realigns the ROM data with valid/index.
module alien_row_sched #(
  parameter int         NUM_ALIENS  = 4,
  parameter int         SPR_W       = 31,
  parameter int         SPR_H       = 21,
  parameter int         PITCH       = 40,
  parameter logic [7:0] TRANSPARENT = 8'h00
) (
  input  logic                  clk_pix,
  input  logic                  reset,
  input  logic [9:0]            sx,
  input  logic [9:0]            sy,
  input  logic                  de,
  input  logic                  frame,
  input  logic [9:0]            row_x,
  input  logic [9:0]            row_y,
  input  logic [NUM_ALIENS-1:0] alive,
  output logic [9:0]            A2address,
  input  logic [7:0]            A2dout,
  output logic [7:0]            pix_out,
  output logic                  pix_valid,
  output logic [2:0]            alien_idx
);

  localparam int COL_W = $clog2(SPR_W + 1);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  logic [9:0]              rx_r;
  logic [9:0]              ry_r;
  logic [NUM_ALIENS-1:0]   amask_r;
  logic [COL_W-1:0]        col_r;
  logic [9:0]              line_base_r;
  logic                    de_d_r;
  logic                    line_in_y_r;
  logic                    prev_hit_r;
  logic [2:0]              prev_k_r;
  logic                    hit_d1_r;
  logic                    hit_d2_r;
  logic [2:0]              k_d1_r;
  logic [2:0]              k_d2_r;

  logic                    in_y_s;
  logic [NUM_ALIENS-1:0]   box_s;
  logic [10:0]             xk_s;
  logic                    hit_s;
  logic [2:0]              k_s;
  logic                    first_s;
  logic [COL_W-1:0]        col_s;

  // Hit/index decode against the frame-latched shadows; boxes are disjoint so OR-ing indices is safe.
  always_comb begin
    in_y_s  = ({1'b0, sy} >= {1'b0, ry_r}) &&
              ({1'b0, sy} <= ({1'b0, ry_r} + 11'(SPR_H - 1)));
    box_s   = {NUM_ALIENS{1'b0}};
    k_s     = 3'd0;
    xk_s    = 11'd0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      xk_s     = {1'b0, rx_r} + 11'(i * PITCH);
      box_s[i] = de && in_y_s && amask_r[i] &&
                 ({1'b0, sx} >= xk_s) && ({1'b0, sx} <= (xk_s + 11'(SPR_W - 1)));
      k_s      = k_s | (box_s[i] ? 3'(i) : 3'd0);
    end
    hit_s   = (state_r == ST_RUN) && (|box_s);
    first_s = !prev_hit_r || (prev_k_r != k_s);
    col_s   = first_s ? {COL_W{1'b0}} : col_r;
  end

  // State, shadows, incremental address generation and the 3-stage output pipeline.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_r     <= ST_WAIT;
      rx_r        <= 10'd0;
      ry_r        <= 10'd0;
      amask_r     <= {NUM_ALIENS{1'b0}};
      col_r       <= {COL_W{1'b0}};
      line_base_r <= 10'd0;
      de_d_r      <= 1'b0;
      line_in_y_r <= 1'b0;
      prev_hit_r  <= 1'b0;
      prev_k_r    <= 3'd0;
      hit_d1_r    <= 1'b0;
      hit_d2_r    <= 1'b0;
      k_d1_r      <= 3'd0;
      k_d2_r      <= 3'd0;
      A2address   <= 10'd0;
      pix_out     <= 8'd0;
      pix_valid   <= 1'b0;
      alien_idx   <= 3'd0;
    end else begin
      case (state_r)
        ST_WAIT: state_r <= frame ? ST_RUN : ST_WAIT;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_WAIT;
      endcase

      if (frame) begin
        rx_r    <= row_x;
        ry_r    <= row_y;
        amask_r <= alive;
      end

      // line_base steps one sprite row per finished line that crossed the row's y band
      de_d_r <= de;
      if (de) begin
        line_in_y_r <= in_y_s;
      end
      if (frame) begin
        line_base_r <= 10'd0;
      end else if ((state_r == ST_RUN) && de_d_r && !de && line_in_y_r) begin
        line_base_r <= line_base_r + 10'(SPR_W);
      end

      prev_hit_r <= hit_s;
      prev_k_r   <= k_s;
      if (hit_s) begin
        col_r     <= col_s + COL_W'(1);
        A2address <= line_base_r + 10'(col_s);
      end

      hit_d1_r <= hit_s;
      k_d1_r   <= k_s;
      hit_d2_r <= hit_d1_r;
      k_d2_r   <= k_d1_r;

      if (hit_d2_r && (A2dout != TRANSPARENT)) begin
        pix_valid <= 1'b1;
        pix_out   <= A2dout;
        alien_idx <= k_d2_r;
      end else begin
        pix_valid <= 1'b0;
        pix_out   <= 8'd0;
        alien_idx <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_alien_row_sched.sv
// Directed bench for alien_row_sched: table of target pixels with hand-computed addresses,
// a per-cycle reference model, and hand-written reset / mid-frame sequences.
module tb_alien_row_sched;

  localparam int NA    = 4;
  localparam int SPR_W = 31;
  localparam int SPR_H = 21;
  localparam int PITCH = 40;

  logic          clk_pix = 1'b0;
  logic          reset;
  logic [9:0]    sx;
  logic [9:0]    sy;
  logic          de;
  logic          frame;
  logic [9:0]    row_x;
  logic [9:0]    row_y;
  logic [NA-1:0] alive;
  logic [9:0]    A2address;
  logic [7:0]    A2dout;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic [2:0]    alien_idx;

  always #5 clk_pix = ~clk_pix;

  alien_row_sched #(
    .NUM_ALIENS(NA), .SPR_W(SPR_W), .SPR_H(SPR_H), .PITCH(PITCH), .TRANSPARENT(8'h00)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .sx(sx), .sy(sy), .de(de), .frame(frame),
    .row_x(row_x), .row_y(row_y), .alive(alive), .A2address(A2address), .A2dout(A2dout),
    .pix_out(pix_out), .pix_valid(pix_valid), .alien_idx(alien_idx)
  );

  function automatic logic [7:0] rom_f(input logic [9:0] a);
    if (a > 10'd650)         return 8'hEE;
    else if (a[1:0] == 2'b11) return 8'h00;
    else                      return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk_pix) A2dout <= rom_f(A2address);

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int tgt_n = -100;
  int cap_addr, cap_pv, cap_po, cap_idx;
  int any_valid, any_addr;

  // reference model state
  logic          m_run = 1'b0;
  logic [9:0]    m_rx = 10'd0, m_ry = 10'd0, m_addr = 10'd0, m_a2 = 10'd0;
  logic [NA-1:0] m_am = '0;
  logic          m_h1 = 1'b0, m_h2 = 1'b0, m_pv = 1'b0;
  logic [2:0]    m_k1 = 3'd0, m_k2 = 3'd0, m_pi = 3'd0;
  logic [7:0]    m_po = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic d, input logic f, input logic r);
    logic       hit;
    logic [2:0] k;
    logic [9:0] a;
    int         xk;
    sx = x; sy = y; de = d; frame = f; reset = r;
    hit = 1'b0; k = 3'd0; a = 10'd0;
    if (m_run && d && (int'(y) >= int'(m_ry)) && (int'(y) <= int'(m_ry) + SPR_H - 1)) begin
      for (int i = 0; i < NA; i++) begin
        xk = int'(m_rx) + i * PITCH;
        if (m_am[i] && (int'(x) >= xk) && (int'(x) <= xk + SPR_W - 1)) begin
          hit = 1'b1;
          k   = 3'(i);
          a   = 10'((int'(y) - int'(m_ry)) * SPR_W + int'(x) - xk);
        end
      end
    end
    @(posedge clk_pix); #1;
    if (r) begin
      m_run = 1'b0; m_rx = 10'd0; m_ry = 10'd0; m_am = '0; m_addr = 10'd0; m_a2 = 10'd0;
      m_h1 = 1'b0; m_h2 = 1'b0; m_k1 = 3'd0; m_k2 = 3'd0; m_pv = 1'b0; m_po = 8'd0; m_pi = 3'd0;
    end else begin
      m_pv = m_h2 && (rom_f(m_a2) != 8'h00);
      m_po = m_pv ? rom_f(m_a2) : 8'h00;
      m_pi = m_pv ? m_k2 : 3'd0;
      m_h2 = m_h1; m_k2 = m_k1; m_a2 = m_addr;
      m_h1 = hit;  m_k1 = k;
      if (hit) m_addr = a;
      if (f) begin
        m_run = 1'b1; m_rx = row_x; m_ry = row_y; m_am = alive;
      end
    end
    chk("cyc_addr", A2address, m_addr);
    chk("cyc_pix_out", pix_out, m_po);
    chk("cyc_pix_valid", pix_valid, m_pv);
    chk("cyc_alien_idx", alien_idx, m_pi);
    chk("cyc_addr_max", int'(A2address <= 10'd650), 1);
    if (pix_valid) any_valid = 1;
    if (A2address != 10'd0) any_addr = 1;
    cyc_n++;
    if (cyc_n == tgt_n + 1) cap_addr = A2address;
    if (cyc_n == tgt_n + 3) begin
      cap_pv = pix_valid; cap_po = pix_out; cap_idx = alien_idx;
    end
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1, input int tx, input int ty);
    tgt_n = -100;
    cap_addr = -1; cap_pv = -1; cap_po = -1; cap_idx = -1;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (x == tx && y == ty) tgt_n = cyc_n;
        cyc(10'(x), 10'(y), 1'b1, 1'b0, 1'b0);
      end
      cyc(10'(x1), 10'(y), 1'b0, 1'b0, 1'b0);
      cyc(10'(x1), 10'(y), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_frame(input int rx, input int ry, input logic [NA-1:0] al);
    row_x = 10'(rx); row_y = 10'(ry); alive = al;
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_cap(input string name, input logic eh, input int ea, input int ei);
    logic ev;
    ev = eh && (rom_f(10'(ea)) != 8'h00);
    if (eh) chk({name, "_addr"}, cap_addr, ea);
    chk({name, "_valid"}, cap_pv, int'(ev));
    chk({name, "_pix"}, cap_po, ev ? int'(rom_f(10'(ea))) : 0);
    chk({name, "_idx"}, cap_idx, ev ? ei : 0);
  endtask

  typedef struct {
    string         name;
    int            rx, ry;
    logic [NA-1:0] al;
    int            x0, x1, y0, y1, tx, ty;
    logic          eh;
    int            ea, ei;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{"org",     100, 50, 4'b0001, 95, 135, 50, 50, 100, 50, 1'b1, 0,   0};
    vt[1]  = '{"org1",    100, 50, 4'b0001, 95, 135, 50, 50, 101, 50, 1'b1, 1,   0};
    vt[2]  = '{"corner",  100, 50, 4'b0001, 95, 135, 50, 70, 130, 70, 1'b1, 650, 0};
    vt[3]  = '{"a1_lo",   100, 50, 4'b1010, 95, 255, 50, 50, 140, 50, 1'b1, 0,   1};
    vt[4]  = '{"a1_hi",   100, 50, 4'b1010, 95, 255, 50, 50, 170, 50, 1'b1, 30,  1};
    vt[5]  = '{"a3_lo",   100, 50, 4'b1010, 95, 255, 50, 50, 220, 50, 1'b1, 0,   3};
    vt[6]  = '{"a3_l2",   100, 50, 4'b1010, 95, 255, 50, 52, 250, 52, 1'b1, 92,  3};
    vt[7]  = '{"dead2",   100, 50, 4'b1010, 95, 255, 50, 50, 180, 50, 1'b0, 0,   0};
    vt[8]  = '{"gap",     100, 50, 4'b1111, 95, 300, 50, 50, 171, 50, 1'b0, 0,   0};
    vt[9]  = '{"clip_x",  620, 50, 4'b0001, 600, 639, 50, 51, 639, 50, 1'b1, 19, 0};
    vt[10] = '{"clip_l2", 620, 50, 4'b0001, 600, 639, 50, 51, 622, 51, 1'b1, 33, 0};
    vt[11] = '{"bottom",  10, 460, 4'b0001, 5, 45, 460, 479, 40, 479, 1'b1, 619, 0};
    vt[12] = '{"all_a3",  0,   0,  4'b1111, 0, 159, 0, 20, 150, 20, 1'b1, 650, 3};
    vt[13] = '{"y_out",   100, 50, 4'b0001, 95, 105, 50, 71, 100, 71, 1'b0, 0,  0};

    row_x = 10'd100; row_y = 10'd50; alive = 4'hF;
    for (int i = 0; i < 3; i++) cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_addr", A2address, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_idx", alien_idx, 0);

    // no frame pulse yet: nothing may draw
    any_valid = 0; any_addr = 0;
    scan(90, 300, 45, 75, -1, -1);
    chk("noframe_valid", any_valid, 0);
    chk("noframe_addr", any_addr, 0);

    for (int v = 0; v < 14; v++) begin
      do_frame(vt[v].rx, vt[v].ry, vt[v].al);
      scan(vt[v].x0, vt[v].x1, vt[v].y0, vt[v].y1, vt[v].tx, vt[v].ty);
      chk_cap(vt[v].name, vt[v].eh, vt[v].ea, vt[v].ei);
    end

    // row_x change without frame pulse keeps the old position until the next frame
    do_frame(100, 50, 4'b0001);
    row_x = 10'd200;
    scan(95, 210, 50, 51, 101, 51);
    chk_cap("midframe_old", 1'b1, 32, 0);
    do_frame(200, 50, 4'b0001);
    scan(95, 210, 50, 50, 200, 50);
    chk_cap("midframe_new", 1'b1, 0, 0);

    // reset in the middle of box 0
    do_frame(100, 50, 4'b0001);
    for (int x = 95; x < 110; x++) cyc(10'(x), 10'd50, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_addr", A2address, 9);
    cyc(10'd110, 10'd50, 1'b1, 1'b0, 1'b1);
    chk("midrst_addr", A2address, 0);
    chk("midrst_pix", pix_out, 0);
    chk("midrst_valid", pix_valid, 0);
    chk("midrst_idx", alien_idx, 0);
    chk("midrst_state", int'(dut.state_r), 0);
    any_valid = 0;
    for (int x = 111; x <= 140; x++) cyc(10'(x), 10'd50, 1'b1, 1'b0, 1'b0);
    // frame together with reset: reset wins
    row_x = 10'd100;
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    scan(95, 135, 50, 50, 100, 50);
    chk_cap("frame_rst", 1'b0, 0, 0);
    chk("frame_rst_addr", cap_addr, 0);
    chk("frame_rst_any", any_valid, 0);
    do_frame(100, 50, 4'b0001);
    scan(95, 135, 50, 50, 100, 50);
    chk_cap("after_rst", 1'b1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
